// File: rtl/boot_image_verifier_if.sv
// Memory-read and hash-feed ports of the boot image verifier, bundled as one interface.
// Both handshakes follow strict valid/ready rules: the initiator (mem_req / hash_valid) holds
// address, data and last stable until the responder completes (mem_ack / hash_ready) in the same cycle.
interface boot_image_verifier_if #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int DIGEST_W = 256
);
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic                hash_start;
    logic                hash_valid;
    logic [DATA_W-1:0]   hash_data;
    logic                hash_last;
    logic                hash_ready;
    logic                hash_done;
    logic [DIGEST_W-1:0] hash_digest;

    modport master (
        output mem_req, mem_addr, hash_start, hash_valid, hash_data, hash_last,
        input  mem_ack, mem_rdata, hash_ready, hash_done, hash_digest
    );

    modport slave (
        input  mem_req, mem_addr, hash_start, hash_valid, hash_data, hash_last,
        output mem_ack, mem_rdata, hash_ready, hash_done, hash_digest
    );
endinterface

// File: rtl/boot_image_verifier.sv
// Streams a boot image from memory into the hash core, then compares the digest with the OTP
// reference. Any tamper, watchdog expiry or empty image ends in DONE with err=1 (fail closed).
module boot_image_verifier #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int DIGEST_W       = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_verify,
    input  logic [ADDR_W-1:0]     img_base,
    input  logic [ADDR_W-1:0]     img_len,
    input  logic                  tamper,
    input  logic [DIGEST_W-1:0]   ref_digest,
    boot_image_verifier_if.master bus,
    output logic                  verify_done,
    output logic                  sig_valid,
    output logic                  err,
    output logic                  busy,
    output logic [2:0]            state_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FETCH, S_FEED, S_WAIT_HASH, S_COMPARE, S_DONE
    } state_e;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                done_q, done_d;
    logic                sig_q, sig_d;
    logic                err_q, err_d;
    logic                is_last;
    logic                wd_expired;
    logic                abort;

    assign is_last    = (cnt_q == len_q - ADDR_W'(1));
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        digest_d = digest_q;
        done_d   = done_q;
        sig_d    = sig_q;
        err_d    = err_q;
        wd_d     = wd_q;
        abort    = 1'b0;

        // Tamper wins over every handshake, so no datapath register moves in that cycle.
        if (busy && tamper) begin
            abort = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_verify) begin
                        addr_d  = img_base;
                        len_d   = img_len;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        sig_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (len_q == '0) abort = 1'b1;
                    else             state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        data_d  = bus.mem_rdata;
                        state_d = S_FEED;
                    end else if (wd_expired) begin
                        abort = 1'b1;
                    end
                end
                S_FEED: begin
                    if (bus.hash_ready) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = is_last ? S_WAIT_HASH : S_FETCH;
                    end else if (wd_expired) begin
                        abort = 1'b1;
                    end
                end
                S_WAIT_HASH: begin
                    if (bus.hash_done) begin
                        digest_d = bus.hash_digest;
                        state_d  = S_COMPARE;
                    end else if (wd_expired) begin
                        abort = 1'b1;
                    end
                end
                S_COMPARE: begin
                    done_d  = 1'b1;
                    sig_d   = (digest_q == ref_digest);
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (abort) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            sig_d   = 1'b0;
            err_d   = 1'b1;
        end

        // Watchdog restarts on every state entry and only runs in the handshake states.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (state_q == S_FETCH || state_q == S_FEED || state_q == S_WAIT_HASH) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            digest_q <= '0;
            wd_q     <= '0;
            done_q   <= 1'b0;
            sig_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            digest_q <= digest_d;
            wd_q     <= wd_d;
            done_q   <= done_d;
            sig_q    <= sig_d;
            err_q    <= err_d;
        end
    end

    assign bus.mem_req    = (state_q == S_FETCH);
    assign bus.mem_addr   = addr_q;
    assign bus.hash_start = (state_q == S_START);
    assign bus.hash_valid = (state_q == S_FEED);
    assign bus.hash_data  = data_q;
    assign bus.hash_last  = (state_q == S_FEED) && is_last;
    assign verify_done    = done_q;
    assign sig_valid      = sig_q;
    assign err            = err_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_boot_image_verifier.sv
// Bench for boot_image_verifier: memory and hash-core responders, a negedge monitor feeding a
// scoreboard of expected addresses/words/results, and directed plus random runs.
module tb_boot_image_verifier;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 32;
    localparam int DIGEST_W       = 256;
    localparam int TIMEOUT_CYCLES = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start_verify = 1'b0;
    logic                tamper = 1'b0;
    logic [ADDR_W-1:0]   img_base = '0;
    logic [ADDR_W-1:0]   img_len = '0;
    logic [DIGEST_W-1:0] ref_digest = '0;
    logic                verify_done, sig_valid, err, busy;
    logic [2:0]          state_dbg;

    boot_image_verifier_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIGEST_W(DIGEST_W)) bus ();

    boot_image_verifier #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIGEST_W(DIGEST_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start_verify(start_verify),
        .img_base(img_base), .img_len(img_len), .tamper(tamper),
        .ref_digest(ref_digest), .bus(bus),
        .verify_done(verify_done), .sig_valid(sig_valid), .err(err),
        .busy(busy), .state_o(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic              exp_last_q[$];
    logic [2:0]        exp_res_q[$];

    int ack_delay = 0, ready_stall = 0;
    bit ack_never = 1'b0, force_done = 1'b0;
    int epoch = 0, seen_epoch = 0;
    int req_cycles = 0, hs_cycles = 0, accepts = 0;
    int lasts_seen = 0, lasts_done = 0;
    logic [DIGEST_W-1:0] digest_acc = '0;

    task automatic check_eq(input string tag, input logic [DIGEST_W-1:0] obs,
                            input logic [DIGEST_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic logic [DIGEST_W-1:0] fold(input logic [DIGEST_W-1:0] acc,
                                                  input logic [DATA_W-1:0] w);
        return {acc[DIGEST_W-33:0], acc[DIGEST_W-1:DIGEST_W-32]} ^ {{(DIGEST_W-DATA_W){1'b0}}, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory and hash-core responders ----------------
    initial begin
        int ack_wait, rwait, dwait;
        ack_wait = 0; rwait = 0; dwait = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        bus.hash_ready = 1'b0; bus.hash_done = 1'b0; bus.hash_digest = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_req && !ack_never) begin
                if (ack_wait >= ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end

            bus.hash_ready = 1'b0;
            if (bus.hash_valid) begin
                if (rwait >= ready_stall) bus.hash_ready = 1'b1;
                else                      rwait++;
            end else begin
                rwait = 0;
            end

            bus.hash_done   = 1'b0;
            bus.hash_digest = {8{$urandom}};
            if (force_done) begin
                bus.hash_done = 1'b1;
            end else if (lasts_seen != lasts_done) begin
                if (dwait >= 2) begin
                    bus.hash_done   = 1'b1;
                    bus.hash_digest = digest_acc;
                    lasts_done++;
                    dwait = 0;
                end else begin
                    dwait++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (seen_epoch != epoch) begin
                seen_epoch = epoch;
                req_cycles = 0; hs_cycles = 0; accepts = 0;
                digest_acc = '0;
            end
            if (bus.hash_start) hs_cycles++;
            if (bus.mem_req) begin
                req_cycles++;
                if (bus.mem_ack) begin
                    if (exp_addr_q.size() == 0) check_eq("addr_unexpected", 1, 0);
                    else check_eq("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
                end
            end
            if (bus.hash_valid) begin
                if (exp_data_q.size() == 0) begin
                    check_eq("data_unexpected", 1, 0);
                end else begin
                    check_eq("hash_data", bus.hash_data, exp_data_q[0]);
                    check_eq("hash_last", bus.hash_last, exp_last_q[0]);
                    if (bus.hash_ready) begin
                        digest_acc = fold(digest_acc, bus.hash_data);
                        accepts++;
                        if (bus.hash_last) lasts_seen++;
                        void'(exp_data_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end else begin
                check_eq("last_unqualified", bus.hash_last, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [ADDR_W-1:0] base, input int len, input int stall,
                             input int delay, input bit flip, input bit words, input logic [2:0] res);
        logic [DIGEST_W-1:0] acc;
        logic [ADDR_W-1:0]   a;
        epoch++;
        ready_stall = stall;
        ack_delay   = delay;
        img_base    = base;
        img_len     = ADDR_W'(len);
        acc = '0;
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_W'(i);
            acc = fold(acc, mem_word(a));
            if (words) begin
                exp_addr_q.push_back(a);
                exp_data_q.push_back(mem_word(a));
                exp_last_q.push_back(i == len - 1);
            end
        end
        ref_digest = flip ? (acc ^ {{(DIGEST_W-1){1'b0}}, 1'b1}) : acc;
        exp_res_q.push_back(res);
        start_verify = 1'b1;
        tick();
        start_verify = 1'b0;
        check_eq("start_pulse", bus.hash_start, 1);
        check_eq("start_flags_clear", {verify_done, sig_valid, err}, 3'b000);
    endtask

    task automatic wait_result(input string tag, input int limit);
        int k;
        k = 0;
        while (!verify_done && k < limit) begin
            tick();
            k++;
        end
        if (!verify_done) check_eq({tag, "_wait_expired"}, 0, 1);
        check_eq(tag, {verify_done, sig_valid, err}, exp_res_q.pop_front());
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_hash_start_count"}, hs_cycles, 1);
    endtask

    task automatic flush_exp();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        exp_res_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        rst = 1'b1;
        repeat (3) tick();
        check_eq("reset_outputs",
                 {verify_done, sig_valid, err, busy, bus.mem_req, bus.hash_valid,
                  bus.hash_start, bus.hash_last}, 8'h00);
        check_eq("reset_addr", bus.mem_addr, 0);
        check_eq("reset_state", state_dbg, 0);
        rst = 1'b0;
        tick();

        // nominal pass
        start_run(16'h0100, 4, 0, 2, 1'b0, 1'b1, 3'b110);
        wait_result("nominal", 200);
        check_eq("nominal_addrs_left", exp_addr_q.size(), 0);
        check_eq("nominal_words_left", exp_data_q.size(), 0);

        // digest mismatch
        start_run(16'h0100, 4, 0, 2, 1'b1, 1'b1, 3'b100);
        wait_result("mismatch", 200);

        // backpressure with address wrap
        start_run(16'hFFFE, 3, 5, 1, 1'b0, 1'b1, 3'b110);
        wait_result("wrap", 300);
        check_eq("wrap_words_left", exp_data_q.size(), 0);

        // zero length: DONE exactly one cycle after START
        start_run(16'h0200, 0, 0, 0, 1'b0, 1'b0, 3'b101);
        wait_result("zero_len", 1);
        check_eq("zero_len_no_req", req_cycles, 0);

        // tamper during the second word's feed
        start_run(16'h0200, 4, 3, 0, 1'b0, 1'b1, 3'b101);
        k = 0;
        while (accepts < 1 && k < 100) begin tick(); k++; end
        k = 0;
        while (!bus.hash_valid && k < 100) begin tick(); k++; end
        check_eq("tamper_pre_valid", bus.hash_valid, 1);
        tamper = 1'b1;
        tick();
        tamper = 1'b0;
        check_eq("tamper_valid_drop", bus.hash_valid, 0);
        check_eq("tamper_req_drop", bus.mem_req, 0);
        check_eq("tamper_result", {verify_done, sig_valid, err}, exp_res_q.pop_front());
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        repeat (3) tick();
        check_eq("tamper_hold", {verify_done, sig_valid, err, busy}, 4'b1010);
        flush_exp();

        // watchdog timeout, then restart from DONE
        ack_never = 1'b1;
        start_run(16'h0300, 2, 0, 0, 1'b0, 1'b0, 3'b101);
        wait_result("timeout", 60);
        check_eq("timeout_fetch_cycles", req_cycles, TIMEOUT_CYCLES);
        ack_never = 1'b0;
        start_run(16'h0010, 2, 1, 0, 1'b0, 1'b1, 3'b110);
        wait_result("restart", 200);

        // random images
        for (int r = 0; r < 4; r++) begin
            start_run(ADDR_W'($urandom), $urandom_range(1, 6), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'(r % 2), 1'b1, (r % 2) ? 3'b100 : 3'b110);
            wait_result("random", 400);
            check_eq("random_words_left", exp_data_q.size(), 0);
        end

        // synchronous reset mid-operation
        start_run(16'h0400, 4, 2, 2, 1'b0, 1'b1, 3'b110);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midreset_outputs",
                 {verify_done, sig_valid, err, busy, bus.mem_req, bus.hash_valid, bus.hash_start},
                 7'h00);
        check_eq("midreset_state", state_dbg, 0);
        flush_exp();
        repeat (4) tick();
        check_eq("midreset_idle", {verify_done, busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
